// File: rtl/auth_code_blk_if.sv
// UART-receiver / power-control bundle of the authorisation block.
// master = byte source and rider sensor side, slave = auth_code_blk.
interface auth_code_blk_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rider_off;
  logic       clr_rx_rdy;
  logic       pwr_up;
  logic       locked;
  logic [2:0] auth_state;

  modport master (
    output rx_rdy, rx_data, rider_off,
    input  clr_rx_rdy, pwr_up, locked, auth_state
  );

  modport slave (
    input  rx_rdy, rx_data, rider_off,
    output clr_rx_rdy, pwr_up, locked, auth_state
  );
endinterface

// File: rtl/auth_code_blk.sv
// Bluetooth power-authorisation FSM: multi-byte unlock code, inter-byte timeout,
// debounced rider-off power-down and lockout after repeated failed attempts.
module auth_code_blk #(
  parameter int                    CODE_LEN  = 1,
  parameter logic [8*CODE_LEN-1:0] CODE      = 8'h67,
  parameter logic [7:0]            STOP_CHAR = 8'h73,
  parameter int                    OFF_DLY   = 1,
  parameter int                    TMO       = 2**20,
  parameter int                    MAX_FAIL  = 3,
  parameter int                    LOCK_CYC  = 2**24
) (
  input logic           clk,
  input logic           rst,
  auth_code_blk_if.slave bus
);

  localparam int IW = $clog2(CODE_LEN) + 1;
  localparam int TW = $clog2(TMO) + 1;
  localparam int OW = $clog2(OFF_DLY) + 1;
  localparam int LW = $clog2(LOCK_CYC) + 1;
  localparam int FW = $clog2(MAX_FAIL) + 1;

  localparam logic [31:0]   CODE_W    = 32'(CODE);
  localparam logic [7:0]    CODE_B0   = CODE_W[8*(CODE_LEN-1) +: 8];
  localparam logic [IW-1:0] IDX_LAST  = IW'(CODE_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(OFF_DLY - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR      = 3'd1,
    ST_STOPPING = 3'd2,
    ST_MATCH    = 3'd3,
    ST_LOCKED   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [OW-1:0] off_cnt, off_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [FW-1:0] fail_cnt, fail_nxt;
  logic          fail_event;
  logic          pwr_up_q, locked_q;

  // Code bytes are stored MS byte first; index 0 is the first byte on the wire.
  function automatic logic [7:0] code_byte(input logic [IW-1:0] i);
    logic [31:0] sh;
    sh = CODE_W >> (8 * (CODE_LEN - 1 - int'(i)));
    return sh[7:0];
  endfunction

  assign bus.clr_rx_rdy = bus.rx_rdy & ~rst;
  assign bus.pwr_up     = pwr_up_q;
  assign bus.locked     = locked_q;
  assign bus.auth_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      idx      <= '0;
      tmo_cnt  <= '0;
      off_cnt  <= '0;
      lock_cnt <= '0;
      fail_cnt <= '0;
      pwr_up_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tmo_cnt  <= tmo_nxt;
      off_cnt  <= off_nxt;
      lock_cnt <= lock_nxt;
      fail_cnt <= fail_nxt;
      pwr_up_q <= (state_nxt == ST_PWR) || (state_nxt == ST_STOPPING);
      locked_q <= (state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tmo_nxt    = tmo_cnt;
    off_nxt    = off_cnt;
    lock_nxt   = lock_cnt;
    fail_nxt   = fail_cnt;
    fail_event = 1'b0;

    case (state)
      ST_OFF: begin
        if (bus.rx_rdy && bus.rx_data == CODE_B0) begin
          if (CODE_LEN == 1) begin
            state_nxt = ST_PWR;
          end else begin
            state_nxt = ST_MATCH;
            idx_nxt   = IW'(1);
            tmo_nxt   = '0;
          end
        end
      end

      ST_MATCH: begin
        if (bus.rx_rdy) begin
          if (bus.rx_data == code_byte(idx)) begin
            tmo_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = ST_PWR;
              fail_nxt  = '0;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            fail_event = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          fail_event = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end

        // The failure that reaches MAX_FAIL sends us to LOCKED with a fresh lock timer.
        if (fail_event) begin
          if (fail_cnt != FAIL_MAX) fail_nxt = fail_cnt + FW'(1);
          state_nxt = (fail_cnt == FAIL_LAST) ? ST_LOCKED : ST_OFF;
          idx_nxt   = '0;
          tmo_nxt   = '0;
          lock_nxt  = '0;
        end
      end

      ST_PWR: begin
        if (bus.rx_rdy && bus.rx_data == STOP_CHAR) begin
          if (bus.rider_off) begin
            state_nxt = ST_OFF;
          end else begin
            state_nxt = ST_STOPPING;
            off_nxt   = '0;
          end
        end
      end

      ST_STOPPING: begin
        // A resume byte takes priority over an expiring rider-off debounce.
        if (bus.rx_rdy && bus.rx_data == CODE_B0) begin
          state_nxt = ST_PWR;
          off_nxt   = '0;
        end else if (bus.rider_off) begin
          if (off_cnt == OFF_LAST) begin
            state_nxt = ST_OFF;
            off_nxt   = '0;
          end else begin
            off_nxt = off_cnt + OW'(1);
          end
        end else begin
          off_nxt = '0;
        end
      end

      ST_LOCKED: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = ST_OFF;
          fail_nxt  = '0;
          lock_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + LW'(1);
        end
      end

      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_auth_code_blk.sv
// Directed bench for auth_code_blk with a two-byte code "gi", short timers
// and hand-computed expected state/pwr_up/locked values.
module tb_auth_code_blk;

  localparam logic [7:0] B_G  = 8'h67;
  localparam logic [7:0] B_I  = 8'h69;
  localparam logic [7:0] B_S  = 8'h73;
  localparam logic [7:0] B_X  = 8'h78;
  localparam logic [7:0] B_AA = 8'hAA;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  auth_code_blk_if bus();

  auth_code_blk #(
    .CODE_LEN (2),
    .CODE     (16'h6769),
    .STOP_CHAR(8'h73),
    .OFF_DLY  (8),
    .TMO      (32),
    .MAX_FAIL (3),
    .LOCK_CYC (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int st, input int pwr, input int lk);
    checkOutput({tag, ".state"},  32'(bus.auth_state), 32'(st));
    checkOutput({tag, ".pwr_up"}, 32'(bus.pwr_up),     32'(pwr));
    checkOutput({tag, ".locked"}, 32'(bus.locked),     32'(lk));
  endtask

  // Presents one byte for a single cycle starting at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    #1;
    checkOutput("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd1);
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.rx_rdy    = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rider_off = 1'b0;
    #2;
    checkAll("reset", 0, 0, 0);
    checkOutput("reset.clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
    bus.rx_rdy = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    checkOutput("idle.clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);

    $display("[TB] unlock with junk byte first");
    applyStimulus(B_AA);
    checkAll("t1.junk", 0, 0, 0);
    applyStimulus(B_G);
    checkAll("t1.g", 3, 0, 0);
    applyStimulus(B_I);
    checkAll("t1.i", 1, 1, 0);

    $display("[TB] stop with rider off");
    bus.rider_off = 1'b1;
    applyStimulus(B_S);
    checkAll("t2.s", 0, 0, 0);
    bus.rider_off = 1'b0;

    $display("[TB] stop with rider on, debounce");
    applyStimulus(B_G);
    applyStimulus(B_I);
    checkAll("t3.unlock", 1, 1, 0);
    applyStimulus(B_S);
    checkAll("t3.s", 2, 1, 0);
    applyStimulus(B_S);
    checkAll("t3.s_repeat", 2, 1, 0);
    bus.rider_off = 1'b1;
    tick(5);
    checkAll("t3.pulse", 2, 1, 0);
    bus.rider_off = 1'b0;
    tick(1);
    checkAll("t3.drop", 2, 1, 0);
    bus.rider_off = 1'b1;
    tick(7);
    checkAll("t3.hold7", 2, 1, 0);
    tick(1);
    checkAll("t3.hold8", 0, 0, 0);
    bus.rider_off = 1'b0;

    $display("[TB] resume from STOPPING at debounce expiry");
    applyStimulus(B_G);
    applyStimulus(B_I);
    applyStimulus(B_S);
    checkAll("t4.s", 2, 1, 0);
    bus.rider_off = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      checkOutput("t4.pwr_hold", 32'(bus.pwr_up), 32'd1);
    end
    applyStimulus(B_G);
    checkAll("t4.resume", 1, 1, 0);

    $display("[TB] three failed attempts then lockout");
    applyStimulus(B_S);
    checkAll("t5.off", 0, 0, 0);
    bus.rider_off = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(B_G);
      checkAll("t5.g", 3, 0, 0);
      applyStimulus(B_X);
      if (k < 2) checkAll("t5.x", 0, 0, 0);
      else       checkAll("t5.x_lock", 4, 0, 1);
    end
    applyStimulus(B_G);
    checkAll("t5.lock_g", 4, 0, 1);
    applyStimulus(B_I);
    checkAll("t5.lock_i", 4, 0, 1);
    tick(61);
    checkAll("t5.lock63", 4, 0, 1);
    tick(1);
    checkAll("t5.lock64", 0, 0, 0);
    applyStimulus(B_G);
    applyStimulus(B_I);
    checkAll("t5.unlock", 1, 1, 0);

    $display("[TB] inter-byte timeout counts as a failure");
    bus.rider_off = 1'b1;
    applyStimulus(B_S);
    bus.rider_off = 1'b0;
    applyStimulus(B_G);
    checkAll("t6.g", 3, 0, 0);
    tick(31);
    checkAll("t6.idle31", 3, 0, 0);
    tick(1);
    checkAll("t6.idle32", 0, 0, 0);
    applyStimulus(B_G);
    applyStimulus(B_X);
    checkAll("t6.fail2", 0, 0, 0);
    applyStimulus(B_G);
    applyStimulus(B_X);
    checkAll("t6.fail3", 4, 0, 1);

    $display("[TB] asynchronous reset");
    #2 rst = 1'b1;
    #1 checkAll("t6.rst_locked", 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    applyStimulus(B_G);
    checkAll("t6.match", 3, 0, 0);
    #2 rst = 1'b1;
    #1 checkAll("t6.rst_match", 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    applyStimulus(B_G);
    applyStimulus(B_I);
    checkAll("t6.pwr", 1, 1, 0);
    #2 rst = 1'b1;
    #1 checkAll("t6.rst_pwr", 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    checkAll("t6.after_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
